enemy_formation_scheduler: RTL and testbench

Sequences the single shared enemy sprite drawer across a grid of enemies once per frame. On a frame trigger it walks every grid slot in row-major order, skips dead enemies, and computes each live enemy's screen position from the formation origin. It starts the drawer with a one-cycle enable, holds the position stable until the drawer reports done, then moves on. It sits between the game-logic block, which owns the alive mask and formation origin, and the enemy drawer, whose pixel outputs go to the VGA adapter.

---
 rtl/enemy_sched_pkg.sv | 18 +
 rtl/formation_pos_counter.sv | 63 ++++++
 rtl/enemy_formation_scheduler.sv | 121 ++++++++++++
 tb/tb_enemy_formation_scheduler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_sched_pkg.sv
// Shared state encoding and default formation geometry for the enemy scheduler.
// Game logic imports the same constants so both sides agree on the grid shape.
package enemy_sched_pkg;

  localparam int DEF_COLS   = 5;
  localparam int DEF_ROWS   = 3;
  localparam int DEF_X_STEP = 36;
  localparam int DEF_Y_STEP = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ISSUE,
    ST_WAIT,
    ST_FINISH
  } sched_state_t;

endpackage

// File: rtl/formation_pos_counter.sv
// Walks grid slots in row-major order, keeping incremental X/Y sprite origins.
// One slot per advance; position outputs are registered and valid the cycle after clear/advance.
module formation_pos_counter
  import enemy_sched_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int X_STEP = DEF_X_STEP,
  parameter int Y_STEP = DEF_Y_STEP,
  parameter int IDX_W  = $clog2(COLS * ROWS)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             advance,
  input  logic [8:0]       form_x,
  input  logic [7:0]       form_y,
  output logic [IDX_W-1:0] idx,
  output logic             last,
  output logic [8:0]       draw_x_next,
  output logic [7:0]       draw_y_next
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [8:0]       base_x;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx         <= '0;
      col         <= '0;
      row         <= '0;
      base_x      <= '0;
      draw_x_next <= '0;
      draw_y_next <= '0;
    end else if (clear) begin
      idx         <= '0;
      col         <= '0;
      row         <= '0;
      base_x      <= form_x;
      draw_x_next <= form_x;
      draw_y_next <= form_y;
    end else if (advance) begin
      idx <= idx + IDX_W'(1);
      // X restarts from the snapped origin at each row wrap; sums wrap mod 512/256
      if (col == COL_W'(COLS - 1)) begin
        col         <= '0;
        row         <= row + ROW_W'(1);
        draw_x_next <= base_x;
        draw_y_next <= draw_y_next + 8'(Y_STEP);
      end else begin
        col         <= col + COL_W'(1);
        draw_x_next <= draw_x_next + 9'(X_STEP);
      end
    end
  end

  assign last = (row == ROW_W'(ROWS - 1)) && (col == COL_W'(COLS - 1));

endmodule

// File: rtl/enemy_formation_scheduler.sv
// Sequences the shared enemy sprite drawer over every live slot once per frame.
// First draw_en k+2 cycles after frame_start (k dead slots first); stalls in WAIT until draw_done.
module enemy_formation_scheduler
  import enemy_sched_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int X_STEP = DEF_X_STEP,
  parameter int Y_STEP = DEF_Y_STEP
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             frame_start,
  input  logic [ROWS*COLS-1:0]             alive,
  input  logic [8:0]                       form_x,
  input  logic [7:0]                       form_y,
  input  logic                             draw_done,
  output logic                             draw_en,
  output logic [8:0]                       draw_x,
  output logic [7:0]                       draw_y,
  output logic                             busy,
  output logic                             frame_done,
  output logic [$clog2(ROWS*COLS+1)-1:0]   drawn_count
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(N + 1);

  sched_state_t     state;
  logic [N-1:0]     alive_snap;
  logic [CNT_W-1:0] run_count;
  logic [IDX_W-1:0] idx;
  logic             last;
  logic [8:0]       pos_x;
  logic [7:0]       pos_y;
  logic             clear;
  logic             advance;
  logic             slot_live;

  assign slot_live = alive_snap[idx];
  assign clear     = (state == ST_IDLE) && frame_start;
  assign advance   = !last && (((state == ST_SCAN) && !slot_live) ||
                               ((state == ST_WAIT) && draw_done));

  formation_pos_counter #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .X_STEP (X_STEP),
    .Y_STEP (Y_STEP),
    .IDX_W  (IDX_W)
  ) u_pos (
    .clk         (clk),
    .resetn      (resetn),
    .clear       (clear),
    .advance     (advance),
    .form_x      (form_x),
    .form_y      (form_y),
    .idx         (idx),
    .last        (last),
    .draw_x_next (pos_x),
    .draw_y_next (pos_y)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      alive_snap  <= '0;
      run_count   <= '0;
      draw_en     <= 1'b0;
      draw_x      <= '0;
      draw_y      <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      drawn_count <= '0;
    end else begin
      draw_en    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            alive_snap <= alive;
            run_count  <= '0;
            busy       <= 1'b1;
            state      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (slot_live) begin
            draw_x  <= pos_x;
            draw_y  <= pos_y;
            draw_en <= 1'b1;
            state   <= ST_ISSUE;
          end else if (last) begin
            frame_done <= 1'b1;
            state      <= ST_FINISH;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (draw_done) begin
            run_count <= run_count + CNT_W'(1);
            if (last) begin
              frame_done <= 1'b1;
              state      <= ST_FINISH;
            end else begin
              state <= ST_SCAN;
            end
          end
        end
        ST_FINISH: begin
          drawn_count <= run_count;
          busy        <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_formation_scheduler.sv
// Directed + randomized bench: a cycle-cost model of the frame walk predicts every draw_en
// cycle, sprite position, frame_done cycle, busy span and drawn_count.
module tb_enemy_formation_scheduler;

  logic        clk = 1'b0;
  logic        resetn;
  logic        frame_start;
  logic [14:0] alive;
  logic [8:0]  form_x;
  logic [7:0]  form_y;
  logic        draw_done;
  logic        draw_en;
  logic [8:0]  draw_x;
  logic [7:0]  draw_y;
  logic        busy;
  logic        frame_done;
  logic [3:0]  drawn_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int en_cyc[$];
  int en_x[$];
  int en_y[$];
  int fd_cnt = 0;
  int fd_cyc = 0;
  int busy_cycles = 0;
  int unstable = 0;
  bit hold = 0;
  logic [8:0] hx;
  logic [7:0] hy;
  int last_t0 = 0;

  int drv_lat = 1;
  bit pend = 0;
  int cnt = 0;

  enemy_formation_scheduler dut (
    .clk         (clk),
    .resetn      (resetn),
    .frame_start (frame_start),
    .alive       (alive),
    .form_x      (form_x),
    .form_y      (form_y),
    .draw_done   (draw_done),
    .draw_en     (draw_en),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .busy        (busy),
    .frame_done  (frame_done),
    .drawn_count (drawn_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Drawer model: draw_done exactly drv_lat cycles after the draw_en cycle.
  always @(posedge clk) begin
    #1;
    draw_done = 1'b0;
    if (pend) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        draw_done = 1'b1;
        pend = 0;
      end
    end
    if (draw_en === 1'b1) begin
      pend = 1;
      cnt = drv_lat;
    end
  end

  always @(negedge clk) begin
    if (draw_en === 1'b1) begin
      en_cyc.push_back(cyc);
      en_x.push_back(int'(draw_x));
      en_y.push_back(int'(draw_y));
      hold = 1;
      hx = draw_x;
      hy = draw_y;
    end else if (hold) begin
      if (draw_x !== hx || draw_y !== hy) unstable++;
      if (draw_done) hold = 0;
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (busy === 1'b1) busy_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered at posedge+1; returns at posedge+1 of the cycle after frame_done.
  task automatic run_frame(input logic [14:0] mask, input logic [8:0] fx, input logic [7:0] fy,
                           input int lat, input bit disturb);
    int t0, exp_cyc, nexp, base_fd, budget;
    en_cyc.delete();
    en_x.delete();
    en_y.delete();
    unstable = 0;
    busy_cycles = 0;
    hold = 0;
    drv_lat = lat;
    alive = mask;
    form_x = fx;
    form_y = fy;
    frame_start = 1'b1;
    t0 = cyc;
    last_t0 = t0;
    base_fd = fd_cnt;
    step();
    frame_start = 1'b0;
    if (disturb) begin
      repeat (6) step();
      alive = ~mask;
      form_x = fx + 9'd100;
      form_y = fy + 8'd50;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
    end
    budget = 15 * (lat + 2) + 40;
    for (int i = 0; i < budget; i++) begin
      if (fd_cnt != base_fd) break;
      step();
    end
    check("frame_done_pulses", fd_cnt - base_fd, 1);
    check("frame_done_width", frame_done, 1'b0);
    check("busy_after_frame", busy, 1'b0);

    exp_cyc = t0 + 1;
    nexp = 0;
    for (int i = 0; i < 15; i++) begin
      if (mask[i]) begin
        if (nexp < en_cyc.size()) begin
          check("draw_en_cycle", en_cyc[nexp] - t0, exp_cyc + 1 - t0);
          check("draw_x", en_x[nexp], (int'(fx) + (i % 5) * 36) % 512);
          check("draw_y", en_y[nexp], (int'(fy) + (i / 5) * 24) % 256);
        end
        nexp++;
        exp_cyc += lat + 2;
      end else begin
        exp_cyc += 1;
      end
    end
    check("draw_en_count", en_cyc.size(), nexp);
    check("frame_done_cycle", fd_cyc - t0, exp_cyc - t0);
    check("busy_cycles", busy_cycles, exp_cyc - t0);
    check("drawn_count", drawn_count, nexp);
    check("pos_stable", unstable, 0);
  endtask

  initial begin
    resetn = 1'b0;
    frame_start = 1'b0;
    alive = '0;
    form_x = '0;
    form_y = '0;
    repeat (2) step();
    check("rst_draw_en", draw_en, 1'b0);
    check("rst_draw_x", draw_x, 9'd0);
    check("rst_draw_y", draw_y, 8'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_drawn_count", drawn_count, 4'd0);
    resetn = 1'b1;
    step();

    // Full formation, slow drawer.
    run_frame(15'h7fff, 9'd10, 8'd5, 560, 0);
    if (en_x.size() == 15) begin
      check("slot7_x", en_x[7], 82);
      check("slot7_y", en_y[7], 29);
      check("slot14_x", en_x[14], 154);
      check("slot14_y", en_y[14], 53);
    end

    // Empty mask, started the cycle right after FINISH.
    run_frame(15'h0000, 9'd33, 8'd44, 3, 0);
    check("empty_done_at_T16", fd_cyc - last_t0, 16);

    // Only the last slot alive.
    run_frame(15'h4000, 9'd20, 8'd30, 4, 0);
    if (en_cyc.size() == 1) begin
      check("bit14_en_at_T16", en_cyc[0] - last_t0, 16);
      check("bit14_x", en_x[0], 164);
      check("bit14_y", en_y[0], 78);
    end

    // X wrap past 511, Y wrap past 255.
    run_frame(15'h7fff, 9'd500, 8'd250, 2, 0);
    if (en_x.size() == 15) begin
      check("wrap_col1_x", en_x[1], 24);
      check("wrap_row1_y", en_y[5], 18);
    end

    // Inputs and frame_start changed mid-frame must not disturb the snapshot.
    run_frame(15'($urandom) | 15'h0001, 9'($urandom), 8'($urandom), 12, 1);
    repeat (3) step();
    check("no_queued_frame", busy, 1'b0);

    for (int r = 0; r < 6; r++) begin
      run_frame(15'($urandom), 9'($urandom), 8'($urandom), $urandom_range(1, 6), 0);
    end

    // Asynchronous reset while the drawer is mid-sprite.
    drv_lat = 560;
    alive = 15'h7fff;
    form_x = 9'd10;
    form_y = 8'd5;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    repeat (10) step();
    check("pre_reset_busy", busy, 1'b1);
    check("pre_reset_draw_x", draw_x, 9'd10);
    resetn = 1'b0;
    #1;
    check("arst_draw_en", draw_en, 1'b0);
    check("arst_draw_x", draw_x, 9'd0);
    check("arst_draw_y", draw_y, 8'd0);
    check("arst_busy", busy, 1'b0);
    check("arst_frame_done", frame_done, 1'b0);
    check("arst_drawn_count", drawn_count, 4'd0);
    pend = 0;
    #5;
    resetn = 1'b1;
    step();
    step();
    check("post_reset_idle", busy, 1'b0);
    run_frame(15'($urandom) | 15'h0001, 9'($urandom), 8'($urandom), 3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
